// File: rtl/flappy_pkg.sv
// Shared types and default timing for the flappy bird input front-end.
// Holds the per-button channel FSM state type and the default debounce /
// auto-repeat constants used by the game core and its bench.
package flappy_pkg;

   // Per-button channel FSM: waiting for press, waiting for first repeat,
   // repeating at the repeat period.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } chan_state_e;

   localparam int unsigned DEF_DEB_CYCLES    = 16;
   localparam int unsigned DEF_REPEAT_DELAY  = 4096;
   localparam int unsigned DEF_REPEAT_PERIOD = 1024;
   localparam int unsigned DEF_CNT_W         = 13;

   localparam int unsigned DROP_W = 8;

endpackage : flappy_pkg

// File: rtl/flappy_btn_channel.sv
// One button channel: 2-flop synchroniser, debounce, press/auto-repeat FSM.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   ena           : synchronous clear when low
//   btn_raw       : asynchronous raw button input
//   stable        : debounced button level (registered)
//   event_strobe  : one-cycle press / auto-repeat event (registered)
module flappy_btn_channel
   import flappy_pkg::*;
#(
   parameter int unsigned DEB_CYCLES    = DEF_DEB_CYCLES,
   parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
   parameter int unsigned CNT_W         = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic btn_raw,
   output logic stable,
   output logic event_strobe
);

   localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

   logic             sync0;
   logic             sync1;
   logic [CNT_W-1:0] deb_cnt;

   chan_state_e      state;
   chan_state_e      state_nxt;
   logic [CNT_W-1:0] rep_cnt;
   logic [CNT_W-1:0] rep_cnt_nxt;
   logic             emit_c;

   // Synchroniser and debounce: stable toggles only after DEB_CYCLES
   // consecutive cycles of disagreement with the synchronised input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync0   <= 1'b0;
         sync1   <= 1'b0;
         stable  <= 1'b0;
         deb_cnt <= '0;
      end else if (!ena) begin
         sync0   <= 1'b0;
         sync1   <= 1'b0;
         stable  <= 1'b0;
         deb_cnt <= '0;
      end else begin
         sync0 <= btn_raw;
         sync1 <= sync0;
         if (sync1 == stable) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            stable  <= ~stable;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + CNT_W'(1);
         end
      end
   end

   // FSM state register, repeat counter and registered event strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         rep_cnt      <= '0;
         event_strobe <= 1'b0;
      end else if (!ena) begin
         state        <= ST_IDLE;
         rep_cnt      <= '0;
         event_strobe <= 1'b0;
      end else begin
         state        <= state_nxt;
         rep_cnt      <= rep_cnt_nxt;
         event_strobe <= emit_c;
      end
   end

   // Next state. IDLE is only ever entered with stable low, so stable high
   // while in IDLE is the rising edge of the debounced level.
   always_comb begin
      state_nxt   = state;
      rep_cnt_nxt = rep_cnt;
      case (state)
         ST_IDLE: begin
            if (stable) begin
               state_nxt   = ST_DELAY;
               rep_cnt_nxt = '0;
            end
         end
         ST_DELAY: begin
            if (!stable) begin
               state_nxt   = ST_IDLE;
               rep_cnt_nxt = '0;
            end else if (rep_cnt == DELAY_LAST) begin
               state_nxt   = ST_REPEAT;
               rep_cnt_nxt = '0;
            end else begin
               rep_cnt_nxt = rep_cnt + CNT_W'(1);
            end
         end
         ST_REPEAT: begin
            if (!stable) begin
               state_nxt   = ST_IDLE;
               rep_cnt_nxt = '0;
            end else if (rep_cnt == PERIOD_LAST) begin
               rep_cnt_nxt = '0;
            end else begin
               rep_cnt_nxt = rep_cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt   = ST_IDLE;
            rep_cnt_nxt = '0;
         end
      endcase
   end

   // Event generation: press, end of initial delay, each repeat period.
   always_comb begin
      emit_c = 1'b0;
      case (state)
         ST_IDLE:   emit_c = stable;
         ST_DELAY:  emit_c = stable && (rep_cnt == DELAY_LAST);
         ST_REPEAT: emit_c = stable && (rep_cnt == PERIOD_LAST);
         default:   emit_c = 1'b0;
      endcase
   end

endmodule : flappy_btn_channel

// File: rtl/flappy_input_ctrl.sv
// Flappy bird input front-end: two button channels, pending-event flags,
// frame_tick arbitration into single-cycle commands, and a drop counter.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   ena               : synchronous clear when low (drop_cnt holds)
//   btn_up_raw        : raw up button (ui_in[0])
//   btn_down_raw      : raw down button (ui_in[1])
//   frame_tick        : one-cycle frame pulse, consumes pending events
//   cmd_up, cmd_down  : one-cycle commands, combinational with frame_tick
//   up_lvl, down_lvl  : debounced button levels
//   drop_cnt          : saturating count of coalesced / conflicting events
module flappy_input_ctrl
   import flappy_pkg::*;
#(
   parameter int unsigned DEB_CYCLES    = DEF_DEB_CYCLES,
   parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
   parameter int unsigned CNT_W         = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              btn_up_raw,
   input  logic              btn_down_raw,
   input  logic              frame_tick,
   output logic              cmd_up,
   output logic              cmd_down,
   output logic              up_lvl,
   output logic              down_lvl,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

   logic            ev_up;
   logic            ev_down;
   logic            pend_up;
   logic            pend_down;
   logic            tick_c;
   logic [1:0]      drop_inc_c;
   logic [DROP_W:0] drop_sum_c;
   logic [DROP_W-1:0] drop_nxt_c;

   flappy_btn_channel #(
      .DEB_CYCLES    (DEB_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .CNT_W         (CNT_W)
   ) u_up (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .btn_raw      (btn_up_raw),
      .stable       (up_lvl),
      .event_strobe (ev_up)
   );

   flappy_btn_channel #(
      .DEB_CYCLES    (DEB_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .CNT_W         (CNT_W)
   ) u_down (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .btn_raw      (btn_down_raw),
      .stable       (down_lvl),
      .event_strobe (ev_down)
   );

   assign tick_c   = ena & frame_tick;
   assign cmd_up   = tick_c & pend_up & ~pend_down;
   assign cmd_down = tick_c & pend_down & ~pend_up;

   // Losses: a conflict at a tick drops both; off-tick, an event landing on
   // an already-set flag is coalesced. An event on a tick refills the flag
   // being consumed, so it is never a loss.
   always_comb begin
      drop_inc_c = 2'd0;
      if (tick_c) begin
         drop_inc_c = (pend_up && pend_down) ? 2'd2 : 2'd0;
      end else begin
         drop_inc_c = {1'b0, ev_up & pend_up} + {1'b0, ev_down & pend_down};
      end
      drop_sum_c = {1'b0, drop_cnt} + (DROP_W + 1)'(drop_inc_c);
      drop_nxt_c = drop_sum_c[DROP_W] ? DROP_MAX : drop_sum_c[DROP_W-1:0];
   end

   // Pending flags: set beats the tick clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_up   <= 1'b0;
         pend_down <= 1'b0;
      end else if (!ena) begin
         pend_up   <= 1'b0;
         pend_down <= 1'b0;
      end else begin
         pend_up   <= ev_up | (pend_up & ~tick_c);
         pend_down <= ev_down | (pend_down & ~tick_c);
      end
   end

   // Drop counter holds through ena low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (ena) begin
         drop_cnt <= drop_nxt_c;
      end
   end

endmodule : flappy_input_ctrl
